// File: rtl/sample_sched_pkg.sv
// Shared definitions for the sample scheduler: FSM state encoding,
// configuration address map and the end-of-frame phase helper.
package sample_sched_pkg;

    // Scheduler FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Config addresses 0..NUM_CH-1 select the per-channel trigger phase
    localparam logic [2:0] CFG_ADDR_MASK   = 3'd6;
    localparam logic [2:0] CFG_ADDR_FRAMES = 3'd7;

    // Last phase of a frame (PHASE_MAX) for a given phase width
    function automatic logic [31:0] phase_max(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Lowest-set-bit priority encoder.
// Ports:
//   req_i  request vector, bit 0 has highest priority
//   idx_o  index of the lowest set bit (0 when none set)
//   any_o  at least one request bit is set
module prio_pick #(
    parameter int NUM_CH = 4,
    parameter int IDXW   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    output logic [IDXW-1:0]   idx_o,
    output logic              any_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDXW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Sample scheduler: fires one sample request per channel per frame at a
// programmed trigger phase of the free-running subsample phase, for a
// programmed number of frames (or continuously), and funnels the requests
// from all channels through a single valid/ready port, lowest channel first.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   phase_i             subsample phase, +1 per cycle, wraps
//   cfg_we/addr/wdata   config write (trigger phases, enable mask, frame count)
//   start, stop         run control pulses
//   smp_valid/ready     downstream request handshake
//   smp_chan, smp_phase channel and captured phase of the request
//   busy                scheduler not idle
//   frame_done          one-cycle pulse after each active frame end
//   overrun             sticky: an event was dropped on a still-pending channel
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter int PHASE_W = 10,
    parameter int NUM_CH  = 4,
    parameter int FRAME_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PHASE_W-1:0]        phase_i,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic [PHASE_W-1:0]        cfg_wdata,
    input  logic                      start,
    input  logic                      stop,
    output logic                      smp_valid,
    input  logic                      smp_ready,
    output logic [$clog2(NUM_CH)-1:0] smp_chan,
    output logic [PHASE_W-1:0]        smp_phase,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);

    localparam int CHW = $clog2(NUM_CH);
    localparam logic [PHASE_W-1:0] PhaseMax = PHASE_W'(phase_max(PHASE_W));

    logic [1:0]         state_q, state_d;
    logic [PHASE_W-1:0] trig_cfg_q [NUM_CH];
    logic [NUM_CH-1:0]  mask_cfg_q;
    logic [FRAME_W-1:0] frames_cfg_q;
    logic [PHASE_W-1:0] trig_sh_q [NUM_CH];
    logic [NUM_CH-1:0]  mask_sh_q;
    logic               continuous_q;
    logic [FRAME_W-1:0] frames_left_q;
    logic [NUM_CH-1:0]  pending_q, pending_d;
    logic [PHASE_W-1:0] cap_q [NUM_CH];
    logic               slot_v_q;
    logic [CHW-1:0]     slot_ch_q;
    logic [PHASE_W-1:0] slot_ph_q;
    logic               frame_done_q;
    logic               overrun_q;

    logic               start_ok, active, frame_end, last_frame, slot_free;
    logic               pick_any;
    logic [CHW-1:0]     pick_idx;
    logic [NUM_CH-1:0]  ev, clr, drop;

    assign start_ok   = (state_q == ST_IDLE) && start && !stop;
    // ARM contributes only its phase-0 cycle, which is the first cycle of the run
    assign active     = !stop && ((state_q == ST_RUN) ||
                                  ((state_q == ST_ARM) && (phase_i == '0)));
    assign frame_end  = active && (phase_i == PhaseMax);
    assign last_frame = frame_end && !continuous_q && (frames_left_q == FRAME_W'(1));
    // The slot can take a new request when empty or being accepted this cycle
    assign slot_free  = !slot_v_q || smp_ready;

    prio_pick #(.NUM_CH(NUM_CH), .IDXW(CHW)) u_pick (
        .req_i (pending_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Per-channel event detection; a fresh event on a channel whose previous
    // event is still pending (and not moving to the slot now) is dropped
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            ev[n]        = active && mask_sh_q[n] && (phase_i == trig_sh_q[n]);
            clr[n]       = slot_free && pick_any && (pick_idx == CHW'(n));
            drop[n]      = ev[n] && pending_q[n] && !clr[n];
            pending_d[n] = ev[n] || (pending_q[n] && !clr[n]);
        end
    end

    // Run-control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_ARM;
            ST_ARM: begin
                if (stop)                state_d = ST_IDLE;
                else if (phase_i == '0)  state_d = ST_RUN;
            end
            ST_RUN:   if (stop || last_frame) state_d = ST_DRAIN;
            ST_DRAIN: if ((pending_q == '0) && !slot_v_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Programming registers, writable at any time; a run sees only the shadows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cfg_q   <= '{default: '0};
            mask_cfg_q   <= '0;
            frames_cfg_q <= '0;
        end else if (cfg_we) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (cfg_addr == 3'(n)) trig_cfg_q[n] <= cfg_wdata;
            end
            if (cfg_addr == CFG_ADDR_MASK)   mask_cfg_q   <= cfg_wdata[NUM_CH-1:0];
            if (cfg_addr == CFG_ADDR_FRAMES) frames_cfg_q <= FRAME_W'(cfg_wdata);
        end
    end

    // Run state: shadows, frame counting, pending events and the output slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            trig_sh_q     <= '{default: '0};
            mask_sh_q     <= '0;
            continuous_q  <= 1'b0;
            frames_left_q <= '0;
            pending_q     <= '0;
            cap_q         <= '{default: '0};
            slot_v_q      <= 1'b0;
            slot_ch_q     <= '0;
            slot_ph_q     <= '0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                trig_sh_q     <= trig_cfg_q;
                mask_sh_q     <= mask_cfg_q;
                continuous_q  <= (frames_cfg_q == '0);
                frames_left_q <= frames_cfg_q;
            end else if (frame_end && !continuous_q) begin
                frames_left_q <= frames_left_q - FRAME_W'(1);
            end
            pending_q <= pending_d;
            for (int n = 0; n < NUM_CH; n++) begin
                if (ev[n] && !drop[n]) cap_q[n] <= phase_i;
            end
            if (slot_free) begin
                slot_v_q <= pick_any;
                if (pick_any) begin
                    slot_ch_q <= pick_idx;
                    slot_ph_q <= cap_q[pick_idx];
                end
            end
            frame_done_q <= frame_end;
            if (start_ok)   overrun_q <= 1'b0;
            else if (|drop) overrun_q <= 1'b1;
        end
    end

    assign smp_valid  = slot_v_q;
    assign smp_chan   = slot_ch_q;
    assign smp_phase  = slot_ph_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Self-checking bench for sample_scheduler: a table of single-channel runs,
// hand-written multi-cycle sequences, and randomized runs compared against
// the set of requests the programmed triggers imply.
module tb_sample_scheduler;
    import sample_sched_pkg::*;

    localparam int PHASE_W   = 10;
    localparam int NUM_CH    = 4;
    localparam int FRAME_W   = 8;
    localparam int FRAME_LEN = 1 << PHASE_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PHASE_W-1:0] phase_i;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [PHASE_W-1:0] cfg_wdata;
    logic               start, stop;
    logic               smp_valid, smp_ready;
    logic [1:0]         smp_chan;
    logic [PHASE_W-1:0] smp_phase;
    logic               busy, frame_done, overrun;

    sample_scheduler #(.PHASE_W(PHASE_W), .NUM_CH(NUM_CH), .FRAME_W(FRAME_W)) dut (
        .clk(clk), .rst_n(rst_n), .phase_i(phase_i), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start), .stop(stop),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_chan(smp_chan),
        .smp_phase(smp_phase), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Free-running phase source, updated 1 time unit after each rising edge
    initial begin
        phase_i = '0;
        forever begin
            @(posedge clk);
            #1;
            phase_i = phase_i + 1'b1;
        end
    end

    typedef struct { int chan; int phase; int atPhase; } txn_t;
    typedef struct { int chan; int trig; int expValidAt; int expPhase; } vec_t;

    txn_t seen[$];
    txn_t expQ[$];
    vec_t vecs[6];
    int   nChecks = 0;
    int   nFails  = 0;
    int   fdCount = 0;
    bit   holdPrev = 1'b0;
    bit   randReady = 1'b0;
    int   fd0, n0, found, mask, frames;
    int   trigR[NUM_CH];
    bit   used[64];
    bit   ok;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // Advance one cycle; inputs change 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
        if (randReady) smp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = PHASE_W'(data);
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic waitValid(input int bound, output bit got);
        int n = 0;
        while (!smp_valid && n < bound) begin step(); n++; end
        got = smp_valid;
        checkOutput("timeout_valid", smp_valid, 1);
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (busy && n < bound) begin step(); n++; end
        checkOutput("timeout_idle", busy, 0);
    endtask

    task automatic waitPhase(input int p);
        int n = 0;
        while (int'(phase_i) != p && n < FRAME_LEN + 2) begin step(); n++; end
        checkOutput("timeout_phase", phase_i, p);
    endtask

    // Collects accepted requests and frame-end pulses; a stalled request
    // must still be valid one cycle later
    always @(negedge clk) begin
        if (!rst_n) begin
            holdPrev = 1'b0;
        end else begin
            if (frame_done) fdCount++;
            if (holdPrev) checkOutput("hold_valid", smp_valid, 1);
            if (smp_valid && smp_ready)
                seen.push_back('{int'(smp_chan), int'(smp_phase), int'(phase_i)});
            holdPrev = smp_valid && !smp_ready;
        end
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0; smp_ready = 1'b0;
        vecs[0] = '{0, 5, 7, 5};
        vecs[1] = '{1, 10, 12, 10};
        vecs[2] = '{1, 0, 2, 0};
        vecs[3] = '{2, 1021, 1023, 1021};
        vecs[4] = '{3, 1022, 0, 1022};
        vecs[5] = '{3, 1023, 1, 1023};

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_valid", smp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_chan", smp_chan, 0);
        checkOutput("rst_phase", smp_phase, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step();

        // Single-channel, single-frame runs
        smp_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            applyStimulus(3'(vecs[v].chan), vecs[v].trig);
            applyStimulus(CFG_ADDR_MASK, 1 << vecs[v].chan);
            applyStimulus(CFG_ADDR_FRAMES, 1);
            fd0 = fdCount;
            n0  = seen.size();
            pulseStart();
            waitValid(3 * FRAME_LEN, ok);
            if (ok) begin
                checkOutput("vec_valid_at", phase_i, vecs[v].expValidAt);
                checkOutput("vec_chan", smp_chan, vecs[v].chan);
                checkOutput("vec_phase", smp_phase, vecs[v].expPhase);
            end
            waitIdle(3 * FRAME_LEN);
            checkOutput("vec_frame_done", fdCount - fd0, 1);
            checkOutput("vec_txn_count", seen.size() - n0, 1);
        end

        // Two channels with equal trigger phase drain low channel first
        applyStimulus(3'd0, 100);
        applyStimulus(3'd2, 100);
        applyStimulus(CFG_ADDR_MASK, 5);
        applyStimulus(CFG_ADDR_FRAMES, 1);
        n0 = seen.size();
        pulseStart();
        waitIdle(3 * FRAME_LEN);
        checkOutput("eq_count", seen.size() - n0, 2);
        if (seen.size() - n0 == 2) begin
            checkOutput("eq_chan_a", seen[n0].chan, 0);
            checkOutput("eq_phase_a", seen[n0].phase, 100);
            checkOutput("eq_at_a", seen[n0].atPhase, 102);
            checkOutput("eq_chan_b", seen[n0 + 1].chan, 2);
            checkOutput("eq_phase_b", seen[n0 + 1].phase, 100);
            checkOutput("eq_at_b", seen[n0 + 1].atPhase, 103);
        end

        // Stalled downstream: request held, second event pends, third is dropped
        applyStimulus(3'd1, 10);
        applyStimulus(CFG_ADDR_MASK, 2);
        applyStimulus(CFG_ADDR_FRAMES, 0);
        smp_ready = 1'b0;
        n0 = seen.size();
        pulseStart();
        waitValid(3 * FRAME_LEN, ok);
        checkOutput("stall_at", phase_i, 12);
        checkOutput("stall_chan", smp_chan, 1);
        checkOutput("stall_phase", smp_phase, 10);
        checkOutput("stall_ovr_f1", overrun, 0);
        step();
        waitPhase(12);
        checkOutput("stall_ovr_f2", overrun, 0);
        checkOutput("stall_valid_f2", smp_valid, 1);
        checkOutput("stall_chan_f2", smp_chan, 1);
        step();
        waitPhase(12);
        checkOutput("stall_ovr_f3", overrun, 1);
        checkOutput("stall_phase_f3", smp_phase, 10);
        stop = 1'b1;
        smp_ready = 1'b1;
        step();
        stop = 1'b0;
        waitIdle(64);
        checkOutput("stall_drain_count", seen.size() - n0, 2);
        if (seen.size() - n0 == 2) begin
            checkOutput("stall_drain_chan", seen[n0 + 1].chan, 1);
            checkOutput("stall_drain_phase", seen[n0 + 1].phase, 10);
        end
        checkOutput("stall_ovr_sticky", overrun, 1);
        applyStimulus(CFG_ADDR_MASK, 0);
        applyStimulus(CFG_ADDR_FRAMES, 1);
        pulseStart();
        checkOutput("ovr_cleared_on_start", overrun, 0);
        waitIdle(3 * FRAME_LEN);

        // Start mid-frame: nothing until phase 0, trigger 0 fires each of 3 frames
        applyStimulus(3'd0, 0);
        applyStimulus(CFG_ADDR_MASK, 1);
        applyStimulus(CFG_ADDR_FRAMES, 3);
        waitPhase(500);
        fd0 = fdCount;
        n0  = seen.size();
        pulseStart();
        checkOutput("mid_busy_arm", busy, 1);
        waitIdle(5 * FRAME_LEN);
        checkOutput("mid_frame_done", fdCount - fd0, 3);
        checkOutput("mid_count", seen.size() - n0, 3);
        for (int k = n0; k < seen.size(); k++) begin
            checkOutput("mid_chan", seen[k].chan, 0);
            checkOutput("mid_phase", seen[k].phase, 0);
            checkOutput("mid_at", seen[k].atPhase, 2);
        end

        // Stop before the trigger; config write during the run has no effect
        applyStimulus(3'd0, 300);
        applyStimulus(CFG_ADDR_FRAMES, 0);
        n0  = seen.size();
        fd0 = fdCount;
        pulseStart();
        waitPhase(0);
        waitPhase(100);
        applyStimulus(3'd0, 250);
        waitPhase(200);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checkOutput("stop_drain_busy", busy, 1);
        step();
        checkOutput("stop_idle", busy, 0);
        checkOutput("stop_no_req", seen.size() - n0, 0);
        checkOutput("stop_no_frame", fdCount - fd0, 0);

        // Reset while a request is outstanding
        applyStimulus(3'd0, 50);
        applyStimulus(CFG_ADDR_FRAMES, 0);
        smp_ready = 1'b0;
        pulseStart();
        waitValid(3 * FRAME_LEN, ok);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", smp_valid, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_chan", smp_chan, 0);
        checkOutput("arst_phase", smp_phase, 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        checkOutput("arst_stays_idle", busy, 0);
        checkOutput("arst_no_valid", smp_valid, 0);

        // Randomized runs with a randomly stalling downstream
        randReady = 1'b1;
        for (int r = 0; r < 4; r++) begin
            mask   = $urandom_range(1, 15);
            frames = $urandom_range(1, 2);
            for (int c = 0; c < NUM_CH; c++) begin
                trigR[c] = $urandom_range(0, FRAME_LEN - 1);
                applyStimulus(3'(c), trigR[c]);
            end
            applyStimulus(CFG_ADDR_MASK, mask);
            applyStimulus(CFG_ADDR_FRAMES, frames);
            expQ.delete();
            for (int f = 0; f < frames; f++)
                for (int c = 0; c < NUM_CH; c++)
                    if (mask[c]) expQ.push_back('{c, trigR[c], 0});
            for (int u = 0; u < 64; u++) used[u] = 1'b0;
            n0  = seen.size();
            fd0 = fdCount;
            pulseStart();
            waitIdle(5 * FRAME_LEN);
            checkOutput("rnd_count", seen.size() - n0, expQ.size());
            checkOutput("rnd_frame_done", fdCount - fd0, frames);
            checkOutput("rnd_overrun", overrun, 0);
            for (int e = 0; e < expQ.size(); e++) begin
                found = 0;
                for (int k = n0; k < seen.size() && k - n0 < 64; k++) begin
                    if (found == 0 && !used[k - n0] && seen[k].chan == expQ[e].chan &&
                        seen[k].phase == expQ[e].phase) begin
                        used[k - n0] = 1'b1;
                        found = 1;
                    end
                end
                checkOutput("rnd_match", found, 1);
            end
        end
        randReady = 1'b0;
        smp_ready = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
